// File: rtl/sb_pkg.sv
// Shared types and default geometry for the data-side store buffer.
// The STORE_COALESCE_EN build option is applied in dmem_store_buffer.sv.
package sb_pkg;

  localparam int SB_DEPTH = 4;
  localparam int SB_DW    = 32;
  localparam int SB_AW    = 32;
  localparam int SB_PW    = $clog2(SB_DEPTH);

  typedef struct packed {
    logic [SB_AW-3:0] waddr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

  // Word index of a byte address; the byte offset never takes part in matching.
  function automatic logic [SB_AW-3:0] word_of(input logic [SB_AW-1:0] byte_addr);
    return byte_addr[SB_AW-1:2];
  endfunction

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-first priority matcher over the store-buffer entries.
// It returns the data of the most recently pushed valid entry whose word address matches.
module sb_fwd_match #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int WAW   = 30,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] valid,
  input  logic [PW-1:0]    tail,
  input  logic [WAW-1:0]   lookup,
  input  logic [WAW-1:0]   entry_addr [DEPTH],
  input  logic [DW-1:0]    entry_data [DEPTH],
  output logic             hit,
  output logic [DW-1:0]    data
);

  logic [PW-1:0] idx_s;

  // Walk oldest to youngest so a later (younger) match overrides an earlier one.
  always_comb begin
    hit   = 1'b0;
    data  = {DW{1'b0}};
    idx_s = {PW{1'b0}};
    for (int k = DEPTH; k >= 1; k--) begin
      idx_s = tail - PW'(k);
      if (valid[idx_s] && (entry_addr[idx_s] == lookup)) begin
        hit  = 1'b1;
        data = entry_data[idx_s];
      end else begin
        hit  = hit;
        data = data;
      end
    end
  end

endmodule

// File: rtl/dmem_store_buffer.sv
// Store buffer between the single-cycle core and the data RAM, with load forwarding.
// Build option STORE_COALESCE_EN merges a store into the youngest entry on a word match.
module dmem_store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int DW    = SB_DW,
  parameter int AW    = SB_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memwrite,
  input  logic [AW-1:0] aluout,
  input  logic [DW-1:0] writedata,
  output logic [DW-1:0] readdata,
  output logic          stall,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          wr_valid,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  input  logic          wr_ready,
  output logic          sb_empty
);

  localparam int PW  = $clog2(DEPTH);
  localparam int WAW = AW - 2;

  logic [PW-1:0]  head_r;
  logic [PW-1:0]  tail_r;
  logic [PW:0]    count_r;
  logic [WAW-1:0] ent_addr_r [DEPTH];
  logic [DW-1:0]  ent_data_r [DEPTH];

  logic [WAW-1:0] req_waddr_s;
  logic [DEPTH-1:0] valid_s;
  logic           full_s;
  logic           pop_s;
  logic           push_s;
  logic           coal_s;
  logic           fwd_hit_s;
  logic [DW-1:0]  fwd_data_s;

  assign req_waddr_s = aluout[AW-1:2];
  assign full_s      = (count_r == (PW+1)'(DEPTH));
  assign sb_empty    = (count_r == {(PW+1){1'b0}});
  // Reset suppresses the write handshake in the very cycle it is asserted.
  assign wr_valid    = !sb_empty && !reset;
  assign wr_addr     = {ent_addr_r[head_r], 2'b00};
  assign wr_data     = ent_data_r[head_r];
  assign pop_s       = wr_valid && wr_ready;
  assign rd_addr     = aluout;

`ifdef STORE_COALESCE_EN
  logic [PW-1:0] tail_m1_s;
  assign tail_m1_s = tail_r - PW'(1'b1);
  // Merging into a single entry that is draining this cycle would lose the new data.
  assign coal_s = memwrite && !reset && !sb_empty
                  && (ent_addr_r[tail_m1_s] == req_waddr_s)
                  && !((count_r == (PW+1)'(1'b1)) && pop_s);
`else
  assign coal_s = 1'b0;
`endif

  // Stall depends only on occupancy and the coalesce decision, never on wr_ready.
  assign push_s = memwrite && !reset && !coal_s && !full_s;
  assign stall  = memwrite && !reset && !coal_s && full_s;

  // Entry i is live when its distance from head is below the occupancy.
  always_comb begin
    valid_s = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      valid_s[i] = ({1'b0, PW'(i) - head_r} < count_r);
    end
  end

  sb_fwd_match #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .WAW   (WAW),
    .PW    (PW)
  ) u_fwd (
    .valid      (valid_s),
    .tail       (tail_r),
    .lookup     (req_waddr_s),
    .entry_addr (ent_addr_r),
    .entry_data (ent_data_r),
    .hit        (fwd_hit_s),
    .data       (fwd_data_s)
  );

  assign readdata = fwd_hit_s ? fwd_data_s : rd_data;

  // Head, tail and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
      count_r <= {(PW+1){1'b0}};
    end else begin
      if (push_s) begin
        tail_r <= tail_r + PW'(1'b1);
      end
      if (pop_s) begin
        head_r <= head_r + PW'(1'b1);
      end
      count_r <= count_r + {{PW{1'b0}}, push_s} - {{PW{1'b0}}, pop_s};
    end
  end

  // Entry storage carries no reset; liveness comes from the pointers alone.
  always_ff @(posedge clk) begin
`ifdef STORE_COALESCE_EN
    if (coal_s) begin
      ent_data_r[tail_m1_s] <= writedata;
    end
`endif
    if (push_s) begin
      ent_addr_r[tail_r] <= req_waddr_s;
      ent_data_r[tail_r] <= writedata;
    end
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed plus randomized bench for dmem_store_buffer, checked against a queue model.
// Define STORE_COALESCE_EN for both bench and RTL to cover store coalescing.
module tb_dmem_store_buffer;
  import sb_pkg::*;

  localparam int DEPTH = SB_DEPTH;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] aluout;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        stall;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        wr_valid;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        sb_empty;

  int vectors    = 0;
  int miscompares = 0;

  sb_entry_t model_q [$];

  logic [31:0] obs_rd;
  logic        obs_stall;
  logic        obs_wrv;
  logic [31:0] obs_wa;
  logic [31:0] obs_rdaddr;
  logic        obs_empty;

  dmem_store_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .aluout    (aluout),
    .writedata (writedata),
    .readdata  (readdata),
    .stall     (stall),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .sb_empty  (sb_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Would this store merge into the youngest buffered entry?
  function automatic bit model_coalesce(input bit mw, input logic [29:0] w, input bit pop);
`ifdef STORE_COALESCE_EN
    int n;
    n = model_q.size();
    return mw && (n > 0) && (model_q[n-1].waddr == w) && !((n == 1) && pop);
`else
    return 1'b0 & mw & w[0] & pop;
`endif
  endfunction

  // One clock cycle: drive, compare against the model at negedge, advance the model.
  task automatic step(input bit mw, input logic [31:0] a, input logic [31:0] d,
                      input bit rdy, input logic [31:0] rdd, input bit rst);
    int          n;
    bit          pop;
    bit          coal;
    logic [31:0] exp_rd;
    sb_entry_t   e;
    reset = rst; memwrite = mw; aluout = a; writedata = d;
    wr_ready = rdy; rd_data = rdd;
    @(negedge clk);
    obs_rd = readdata; obs_stall = stall; obs_wrv = wr_valid;
    obs_wa = wr_addr; obs_rdaddr = rd_addr; obs_empty = sb_empty;
    n = model_q.size();
    check("rd_addr", rd_addr, a);
    if (rst) begin
      check("wr_valid_in_reset", {31'h0, wr_valid}, 32'h0);
      check("stall_in_reset", {31'h0, stall}, 32'h0);
    end else begin
      pop  = (n != 0) && rdy;
      coal = model_coalesce(mw, a[31:2], pop);
      check("wr_valid", {31'h0, wr_valid}, {31'h0, n != 0});
      check("sb_empty", {31'h0, sb_empty}, {31'h0, n == 0});
      check("stall", {31'h0, stall}, {31'h0, mw && !coal && (n == DEPTH)});
      if (n != 0) begin
        check("wr_addr", wr_addr, {model_q[0].waddr, 2'b00});
        check("wr_data", wr_data, model_q[0].data);
      end
      exp_rd = rdd;
      for (int i = 0; i < n; i++) begin
        if (model_q[i].waddr == a[31:2]) exp_rd = model_q[i].data;
      end
      check("readdata", readdata, exp_rd);
    end
    @(posedge clk);
    if (rst) begin
      model_q.delete();
    end else begin
      if (coal) begin
        e = model_q[n-1];
        e.data = d;
        model_q[n-1] = e;
      end
      if (pop) void'(model_q.pop_front());
      if (mw && !coal && (n < DEPTH)) begin
        e.waddr = a[31:2];
        e.data  = d;
        model_q.push_back(e);
      end
    end
    #1;
  endtask

  initial begin
    reset = 1'b1; memwrite = 1'b0; aluout = 32'h0; writedata = 32'h0;
    wr_ready = 1'b0; rd_data = 32'h0;

    step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0);
    check("reset_empty", {31'h0, obs_empty}, 32'h1);
    check("reset_wrv", {31'h0, obs_wrv}, 32'h0);

    // single store then forwarded load
    step(1'b1, 32'h10, 32'hAAAA_0001, 1'b0, 32'h5555_5555, 1'b0);
    step(1'b0, 32'h10, 32'h0, 1'b0, 32'h1234_5678, 1'b0);
    check("fwd_basic", obs_rd, 32'hAAAA_0001);
    check("fwd_wrv", {31'h0, obs_wrv}, 32'h1);
    check("fwd_wa", obs_wa, 32'h10);
    check("fwd_empty", {31'h0, obs_empty}, 32'h0);

    // youngest of two same-address stores wins
    step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h20, 32'h1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h20, 32'h2, 1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h20, 32'h0, 1'b0, 32'hFFFF_0000, 1'b0);
    check("youngest_wins", obs_rd, 32'h2);

    // fill, stall, drain in order
    step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 32'h100 + 32'(4 * i), 32'hC0 + 32'(i), 1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h110, 32'hC4, 1'b0, 32'h0, 1'b0);
    check("full_stall", {31'h0, obs_stall}, 32'h1);
    step(1'b1, 32'h110, 32'hC4, 1'b1, 32'h0, 1'b0);
    check("full_stall_ready", {31'h0, obs_stall}, 32'h1);
    check("drain0", obs_wa, 32'h100);
    step(1'b1, 32'h110, 32'hC4, 1'b0, 32'h0, 1'b0);
    check("fifth_accepted", {31'h0, obs_stall}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0);
      check("drain_order", obs_wa, 32'h104 + 32'(4 * i));
    end
    step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("drained_empty", {31'h0, obs_empty}, 32'h1);

    // empty buffer load goes to RAM
    step(1'b0, 32'h40, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0);
    check("ram_load", obs_rd, 32'hDEAD_BEEF);
    check("ram_rdaddr", obs_rdaddr, 32'h40);

    // byte offset ignored
    step(1'b1, 32'h13, 32'h0BAD_F00D, 1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h11, 32'h0, 1'b0, 32'h7777_7777, 1'b0);
    check("offset_wa", obs_wa, 32'h10);
    check("offset_fwd", obs_rd, 32'h0BAD_F00D);

    // reset mid-drain
    step(1'b1, 32'h14, 32'h1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h18, 32'h2, 1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b1);
    check("reset_nowrite", {31'h0, obs_wrv}, 32'h0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0);
    check("after_reset_wrv", {31'h0, obs_wrv}, 32'h0);
    check("after_reset_empty", {31'h0, obs_empty}, 32'h1);

`ifdef STORE_COALESCE_EN
    for (int i = 0; i < 4; i++) step(1'b1, 32'h24 + 32'(4 * i), 32'h50 + 32'(i), 1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h30, 32'h7, 1'b0, 32'h0, 1'b0);
    check("coal_nostall", {31'h0, obs_stall}, 32'h0);
    step(1'b1, 32'h3C, 32'h8, 1'b0, 32'h0, 1'b0);
    check("coal_still_full", {31'h0, obs_stall}, 32'h1);
    step(1'b0, 32'h30, 32'h0, 1'b0, 32'h0, 1'b0);
    check("coal_fwd", obs_rd, 32'h7);
    step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
`endif

    // randomized traffic over a small address window to force matches and wraps
    for (int c = 0; c < 600; c++) begin
      step(1'($urandom_range(0, 1)), {27'h0, 3'($urandom), 2'($urandom)}, $urandom,
           ($urandom_range(0, 2) != 0), $urandom, ($urandom_range(0, 59) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
